// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator behind a valid/ready
// request/response port, with rty re-issue and a strobe timeout.
module wb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RTY_MAX  = 4'(MAX_RETRIES);

  logic [1:0] state_q;
  logic [3:0] rty_q;
  logic [7:0] tmo_q;

  logic fin_ok;
  logic fin_bad;
  logic retry;
  logic rty_spent;
  logic tmo_hit;

  assign cyc_o       = (state_q == S_BUS);
  assign stb_o       = (state_q == S_BUS);
  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);

  assign rty_spent = (rty_q == RTY_MAX);
  assign tmo_hit   = (tmo_q == TMO_LAST);

  // err > ack > rty; the three outcomes are mutually exclusive
  always_comb begin
    fin_ok  = 1'b0;
    fin_bad = 1'b0;
    retry   = 1'b0;
    fin_ok  = !err_i && ack_i;
    retry   = !err_i && !ack_i && rty_i && !rty_spent;
    fin_bad = err_i
            || (!ack_i && rty_i && rty_spent)
            || (!ack_i && !rty_i && tmo_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rty_q       <= '0;
      tmo_q       <= '0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      sel_o       <= '0;
      dat_o       <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            adr_o   <= req_addr_i;
            we_o    <= req_we_i;
            dat_o   <= req_wdata_i;
            sel_o   <= req_sel_i;
            rty_q   <= '0;
            tmo_q   <= '0;
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          unique case (1'b1)
            fin_bad: begin
              rsp_rdata_o <= '0;
              rsp_err_o   <= 1'b1;
              state_q     <= S_RESP;
            end
            fin_ok: begin
              rsp_rdata_o <= we_o ? '0 : dat_i;
              rsp_err_o   <= 1'b0;
              state_q     <= S_RESP;
            end
            retry: begin
              rty_q   <= rty_q + 4'd1;
              state_q <= S_GAP;
            end
            default: tmo_q <= tmo_q + 8'd1;
          endcase
        end
        S_GAP: begin
          tmo_q   <= '0;
          state_q <= S_BUS;
        end
        S_RESP: begin
          if (rsp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
